// File: rtl/riscv_v_twos_comp_sel_block.sv
// Per-element two's complement for packed vector data, with selectable element width.
// Each block lane negates its slice. The carry is chained from lane to lane and restarts at every element boundary.

module riscv_v_twos_comp_sel_lane #(
    parameter int BLOCK_WIDTH = 8
) (
    input  logic [BLOCK_WIDTH-1:0] blk,
    input  logic                   neg,
    input  logic                   cin,
    output logic [BLOCK_WIDTH-1:0] res,
    output logic                   cout
);
    // ~x + cin carries out only when x is zero and a carry arrives.
    assign res  = neg ? (~blk + BLOCK_WIDTH'(cin)) : blk;
    assign cout = neg & cin & (blk == '0);
endmodule

module riscv_v_twos_comp_sel_block #(
    parameter int DATA_WIDTH  = 128,
    parameter int BLOCK_WIDTH = 8,
    parameter int NUM_OSIZES  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            in,
    input  logic [DATA_WIDTH/BLOCK_WIDTH-1:0] complement,
    input  logic [NUM_OSIZES-1:0]            osize_vector,
    input  logic                             merge,
    output logic [DATA_WIDTH-1:0]            out
);
    localparam int NUM_BLOCKS = DATA_WIDTH / BLOCK_WIDTH;

`ifndef SYNTHESIS
    if (DATA_WIDTH % (BLOCK_WIDTH << (NUM_OSIZES - 1)) != 0) begin : g_bad_cfg
        $fatal(1, "DATA_WIDTH must be a multiple of the largest element width");
    end
`endif

    // Bit k is set when block b is the first block of an element of size 2^k blocks.
    function automatic logic [NUM_OSIZES-1:0] align_mask(input int b);
        for (int k = 0; k < NUM_OSIZES; k++)
            align_mask[k] = ((b % (1 << k)) == 0);
    endfunction

    logic [NUM_OSIZES-1:0]                   sel;
    logic [NUM_BLOCKS-1:0][BLOCK_WIDTH-1:0]  nxt;

    // Isolate the lowest set bit, so that a non-one-hot select resolves deterministically.
    assign sel = osize_vector & (~osize_vector + NUM_OSIZES'(1));

    for (genvar b = 0; b < NUM_BLOCKS; b++) begin : gen_blk
        localparam logic [NUM_OSIZES-1:0] ALIGN = align_mask(b);
        logic start, neg, cin, cout;

        if (b == 0) begin : g_first
            assign start = merge | (|(sel & ALIGN));
            assign neg   = start & complement[0];
            assign cin   = start;
        end else begin : g_rest
            // Inside an element, a block inherits the negate request from the element's lowest block.
            assign start = ~merge & (|(sel & ALIGN));
            assign neg   = start ? complement[b] : gen_blk[b-1].neg;
            assign cin   = start | gen_blk[b-1].cout;
        end

        riscv_v_twos_comp_sel_lane #(
            .BLOCK_WIDTH (BLOCK_WIDTH)
        ) u_lane (
            .blk  (in[b*BLOCK_WIDTH +: BLOCK_WIDTH]),
            .neg  (neg),
            .cin  (cin),
            .res  (nxt[b]),
            .cout (cout)
        );
    end

    logic unused_last_cout;
    assign unused_last_cout = gen_blk[NUM_BLOCKS-1].cout;

    always_ff @(posedge clk) begin
        if (rst) out <= '0;
        else     out <= nxt;
    end
endmodule

// File: tb/tb_riscv_v_twos_comp_sel_block.sv
// Directed bench for riscv_v_twos_comp_sel_block: an arithmetic reference model is checked every cycle, and literal checks pin specific results.

module tb_riscv_v_twos_comp_sel_block;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in;
    logic [15:0]  complement;
    logic [3:0]   osize_vector;
    logic         merge;
    logic [127:0] out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    riscv_v_twos_comp_sel_block dut (
        .clk          (clk),
        .rst          (rst),
        .in           (in),
        .complement   (complement),
        .osize_vector (osize_vector),
        .merge        (merge),
        .out          (out)
    );

    function automatic logic [127:0] model(input logic [127:0] d, input logic [15:0] c,
                                           input logic [3:0] os, input logic m);
        int w;
        logic [127:0] mask, elem, res;
        w = 0;
        if (m) w = 128;
        else for (int k = 3; k >= 0; k--) if (os[k]) w = 8 << k;
        if (w == 0) return d;
        mask = (w == 128) ? {128{1'b1}} : ((128'd1 << w) - 128'd1);
        res  = '0;
        for (int e = 0; e < 128 / w; e++) begin
            elem = (d >> (e * w)) & mask;
            if (c[e * w / 8]) elem = (~elem + 128'd1) & mask;
            res = res | (elem << (e * w));
        end
        return res;
    endfunction

    logic [127:0] exp_q;
    logic         mvld = 1'b0;

    always @(posedge clk) begin
        exp_q <= rst ? '0 : model(in, complement, osize_vector, merge);
        mvld  <= 1'b1;
    end

    always @(negedge clk) begin
        if (mvld) begin
            checks++;
            if (out !== exp_q) begin
                errors++;
                $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, out, exp_q);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [127:0] d, input logic [15:0] c, input logic [3:0] os,
                         input logic m);
        in = d; complement = c; osize_vector = os; merge = m;
    endtask

    initial begin
        rst = 1'b1;
        drive(128'h0101_0101_0101_0101_0101_0101_0101_0101, 16'hFFFF, 4'b0001, 1'b0);
        cyc();
        chk("reset_zero", out, 128'h0);
        cyc();
        chk("reset_hold", out, 128'h0);
        rst = 1'b0;
        cyc();
        chk("reset_release", out, {128{1'b1}});

        drive(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_0501, 16'h0001, 4'b0001, 1'b0);
        cyc();
        chk("mode8", out, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_05FF);

        drive(128'h1, 16'h0002, 4'b0010, 1'b0);
        cyc();
        chk("mode16_ignored_bit", out, 128'h1);
        complement = 16'h0001;
        cyc();
        chk("mode16_neg", out, 128'hFFFF);

        drive(128'h1234_5678_0000_0001_0000_0000_8000_0000, 16'hFFFF, 4'b0100, 1'b0);
        cyc();
        chk("mode32_bounds", out, 128'hEDCB_A988_FFFF_FFFF_0000_0000_8000_0000);

        drive(128'h0000_0000_0000_0001_0000_0000_0000_0000, 16'h0101, 4'b1000, 1'b0);
        cyc();
        chk("mode64", out, 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000);

        drive(128'h1, 16'h0001, 4'b0001, 1'b1);
        cyc();
        chk("merge_neg", out, {128{1'b1}});
        complement = 16'h0000;
        cyc();
        chk("merge_pass", out, 128'h1);

        drive(128'h1, 16'h0001, 4'b0110, 1'b0);
        cyc();
        chk("priority_16", out, 128'hFFFF);

        drive(128'hDEAD_BEEF_0000_0001_8000_0000_CAFE_F00D, 16'hFFFF, 4'b0000, 1'b0);
        cyc();
        chk("passthrough", out, 128'hDEAD_BEEF_0000_0001_8000_0000_CAFE_F00D);

        drive(128'h0000_0000_0000_0000_0000_0000_0000_0080, 16'h0001, 4'b0001, 1'b0);
        cyc();
        chk("most_neg8", out, 128'h80);
        rst = 1'b1;
        drive(128'h5, 16'h0001, 4'b0001, 1'b0);
        cyc();
        chk("reset_midstream", out, 128'h0);
        rst = 1'b0;
        cyc();
        chk("resume", out, 128'hFB);

        for (int i = 0; i < 40; i++) begin
            logic [127:0] d;
            d = {$urandom, $urandom, $urandom, $urandom};
            if (i % 3 == 0) d[63:8] = '0;
            drive(d, 16'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0));
            cyc();
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
